multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I core.
- Sequences fetch, decode, execute, memory and writeback over the shared register file, ALU, immediate unit and memory ports.
- Consumes opcode/func3 from the instruction register and the branch comparator result.
- Drives all datapath strobes and selects, the memory handshakes, a retire counter and a trap/halt status.

Parameters:
- MEM_TIMEOUT, 16, max cycles a memory request waits for ack before trapping (≥2).
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  inst[6:0] from IR
- func3  in  3  inst[14:12] from IR
- branch_cond  in  1  comparator result for current branch
- imem_ack  in  1  instruction word valid this cycle
- dmem_ack  in  1  data access complete this cycle
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data request
- dmem_we  out  1  data write (store)
- ir_we  out  1  latch instruction register
- pc_we  out  1  update PC
- pc_sel  out  2  0 pc+4, 1 pc+imm (branch/JAL), 2 ALU result with bit0 cleared (JALR)
- alu_a_sel  out  1  0 rs1, 1 PC
- alu_b_sel  out  1  0 rs2, 1 imm
- rf_we  out  1  register file write
- wb_sel  out  2  0 ALU, 1 load data, 2 pc+4, 3 imm (LUI)
- state_o  out  3  current state encoding
- trap  out  1  sticky: illegal opcode or memory timeout
- halt  out  1  sticky: SYSTEM opcode reached
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset (async, rst_n=0):
  - state=FETCH, instret=0, trap=0, halt=0, wait counter=0.
  - All strobes 0 while rst_n is low.
- Outputs decode combinationally from the state register plus the opcode input (IR stable after DECODE).
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, STOP=5.
- FETCH:
  - imem_req=1, held until imem_ack.
  - On ack: ir_we=1, next DECODE.
- DECODE:
  - One cycle.
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 1110011.
  - Any other opcode: trap=1, next STOP.
  - 1110011: halt=1, next STOP.
  - Otherwise next EXEC.
- EXEC (one cycle):
  - OP / OP-IMM / LUI / AUIPC:
    - alu_b_sel=imm for OP-IMM; alu_a_sel=PC for AUIPC.
    - Next WB.
  - LOAD / STORE: alu_b_sel=imm, next MEM.
  - BRANCH:
    - pc_we=1, pc_sel = branch_cond ? 1 : 0.
    - instret++, next FETCH.
  - JAL: pc_sel=1; JALR: pc_sel=2, alu_b_sel=imm.
    - Both: rf_we=1, wb_sel=2, pc_we=1, instret++, next FETCH.
- MEM:
  - dmem_req=1; dmem_we=1 for STORE.
  - Held until dmem_ack.
  - STORE ack: pc_we=1, pc_sel=0, instret++, next FETCH.
  - LOAD ack: next WB.
- WB:
  - rf_we=1.
  - wb_sel: 1 for LOAD, 3 for LUI, else 0.
  - pc_we=1, pc_sel=0, instret++, next FETCH.
- STOP:
  - Absorbing; all strobes 0.
  - Exit only by reset.
- Timeout:
  - Counter increments each cycle in FETCH/MEM without ack; clears on ack or state change.
  - At MEM_TIMEOUT with no ack: trap=1, next STOP.
  - An ack arriving in the timeout cycle wins.
- instret wraps modulo 2^CNT_W.
- Reset asserted mid-access drops req immediately (async).

Decomposition:
- Shared package rv_pkg:
  - opcode localparams
  - state encodings
  - pc_sel and wb_sel encodings
- No sub-module. Timeout counter and retire counter are inline always blocks.

Test Plan:
- ADDI with imem_ack on first FETCH cycle → states F,D,E,W,F; rf_we=1 in WB with wb_sel=0; instret=1 after 4 cycles.
- LW with dmem_ack delayed 3 cycles → dmem_req high exactly 4 cycles, dmem_we=0; WB wb_sel=1; instret=1.
- BEQ with branch_cond=1, then again with 0 → EXEC pc_we=1 with pc_sel=1, then pc_sel=0; rf_we never asserted.
- Opcode 7'b1111111 → trap=1 one cycle after DECODE; state=5 held for 20 cycles; all strobes 0.
- SW with dmem_ack never asserted, MEM_TIMEOUT=16 → trap=1 after 16 MEM cycles; an ack in cycle 16 instead completes the store.
- rst_n pulsed low during MEM → dmem_req drops asynchronously; state=FETCH, instret=0 after release.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I control definitions: opcode values, control-FSM state encodings
// and datapath select encodings used by the multi-cycle core.
package rv_pkg;

    localparam int unsigned OPC_W   = 7;
    localparam int unsigned STATE_W = 3;

    // Major opcodes (inst[6:0])
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;

    // Control FSM states (visible on state_o)
    localparam logic [STATE_W-1:0] ST_FETCH  = 3'd0;
    localparam logic [STATE_W-1:0] ST_DECODE = 3'd1;
    localparam logic [STATE_W-1:0] ST_EXEC   = 3'd2;
    localparam logic [STATE_W-1:0] ST_MEM    = 3'd3;
    localparam logic [STATE_W-1:0] ST_WB     = 3'd4;
    localparam logic [STATE_W-1:0] ST_STOP   = 3'd5;

    // Next-PC source
    localparam logic [1:0] PC_SEL_PLUS4 = 2'd0;
    localparam logic [1:0] PC_SEL_IMM   = 2'd1;
    localparam logic [1:0] PC_SEL_ALU   = 2'd2;

    // Register-file write-back source
    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_LOAD = 2'd1;
    localparam logic [1:0] WB_SEL_PC4  = 2'd2;
    localparam logic [1:0] WB_SEL_IMM  = 2'd3;

    // True for every opcode the core implements
    function automatic logic opcode_legal(input logic [OPC_W-1:0] opc);
        case (opc)
            OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
            OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_SYSTEM: return 1'b1;
            default:                                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I core.
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) over the shared datapath.
// Inputs : clk, rst_n, opcode/func3 (from IR), branch_cond, imem_ack, dmem_ack
// Outputs: imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, alu_a_sel,
//          alu_b_sel, rf_we, wb_sel (all decoded from state + opcode),
//          state_o, trap/halt (sticky), instret (retired count).
module multicycle_ctrl
    import rv_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           opcode,
    input  logic [2:0]           func3,
    input  logic                 branch_cond,
    input  logic                 imem_ack,
    input  logic                 dmem_ack,
    output logic                 imem_req,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic [1:0]           pc_sel,
    output logic                 alu_a_sel,
    output logic                 alu_b_sel,
    output logic                 rf_we,
    output logic [1:0]           wb_sel,
    output logic [2:0]           state_o,
    output logic                 trap,
    output logic                 halt,
    output logic [CNT_W-1:0]     instret
);

    // Wait counter only needs to reach MEM_TIMEOUT-1
    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT);

    logic [STATE_W-1:0] state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               trap_q, trap_d;
    logic               halt_q, halt_d;
    logic [CNT_W-1:0]   instret_q;

    logic       timeout_c;
    logic       retire_c;
    logic       imem_req_c, dmem_req_c, dmem_we_c, ir_we_c, pc_we_c;
    logic       alu_a_sel_c, alu_b_sel_c, rf_we_c;
    logic [1:0] pc_sel_c, wb_sel_c;

    // func3 is decoded by the datapath (ALU/branch/load units), not here
    logic unused_func3_c;
    assign unused_func3_c = ^func3;

    assign timeout_c = (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

    // Next-state and strobe decode
    always_comb begin
        state_d     = state_q;
        wait_d      = '0;
        trap_d      = trap_q;
        halt_d      = halt_q;
        retire_c    = 1'b0;
        imem_req_c  = 1'b0;
        dmem_req_c  = 1'b0;
        dmem_we_c   = 1'b0;
        ir_we_c     = 1'b0;
        pc_we_c     = 1'b0;
        pc_sel_c    = PC_SEL_PLUS4;
        alu_a_sel_c = 1'b0;
        alu_b_sel_c = 1'b0;
        rf_we_c     = 1'b0;
        wb_sel_c    = WB_SEL_ALU;

        case (state_q)
            ST_FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ack) begin
                    ir_we_c = 1'b1;
                    state_d = ST_DECODE;
                end else if (timeout_c) begin
                    trap_d  = 1'b1;
                    state_d = ST_STOP;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            ST_DECODE: begin
                if (!opcode_legal(opcode)) begin
                    trap_d  = 1'b1;
                    state_d = ST_STOP;
                end else if (opcode == OPC_SYSTEM) begin
                    halt_d  = 1'b1;
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                case (opcode)
                    OPC_OP, OPC_LUI: state_d = ST_WB;
                    OPC_OP_IMM: begin
                        alu_b_sel_c = 1'b1;
                        state_d     = ST_WB;
                    end
                    OPC_AUIPC: begin
                        // pc + imm
                        alu_a_sel_c = 1'b1;
                        alu_b_sel_c = 1'b1;
                        state_d     = ST_WB;
                    end
                    OPC_LOAD, OPC_STORE: begin
                        alu_b_sel_c = 1'b1;
                        state_d     = ST_MEM;
                    end
                    OPC_BRANCH: begin
                        pc_we_c  = 1'b1;
                        pc_sel_c = branch_cond ? PC_SEL_IMM : PC_SEL_PLUS4;
                        retire_c = 1'b1;
                        state_d  = ST_FETCH;
                    end
                    OPC_JAL, OPC_JALR: begin
                        pc_sel_c    = (opcode == OPC_JAL) ? PC_SEL_IMM : PC_SEL_ALU;
                        alu_b_sel_c = (opcode == OPC_JALR);
                        rf_we_c     = 1'b1;
                        wb_sel_c    = WB_SEL_PC4;
                        pc_we_c     = 1'b1;
                        retire_c    = 1'b1;
                        state_d     = ST_FETCH;
                    end
                    default: begin
                        // IR changed under us; treat as illegal
                        trap_d  = 1'b1;
                        state_d = ST_STOP;
                    end
                endcase
            end

            ST_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = (opcode == OPC_STORE);
                if (dmem_ack) begin
                    if (opcode == OPC_STORE) begin
                        pc_we_c  = 1'b1;
                        retire_c = 1'b1;
                        state_d  = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (timeout_c) begin
                    trap_d  = 1'b1;
                    state_d = ST_STOP;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            ST_WB: begin
                rf_we_c  = 1'b1;
                wb_sel_c = (opcode == OPC_LOAD) ? WB_SEL_LOAD :
                           (opcode == OPC_LUI)  ? WB_SEL_IMM  : WB_SEL_ALU;
                pc_we_c  = 1'b1;
                retire_c = 1'b1;
                state_d  = ST_FETCH;
            end

            ST_STOP: state_d = ST_STOP;

            default: state_d = ST_STOP;
        endcase
    end

    // State, wait counter and sticky status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            wait_q  <= '0;
            trap_q  <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            trap_q  <= trap_d;
            halt_q  <= halt_d;
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (retire_c) begin
            instret_q <= instret_q + CNT_W'(1);
        end
    end

    // Strobes are forced low the moment reset asserts, even mid-access
    assign imem_req  = rst_n & imem_req_c;
    assign dmem_req  = rst_n & dmem_req_c;
    assign dmem_we   = rst_n & dmem_we_c;
    assign ir_we     = rst_n & ir_we_c;
    assign pc_we     = rst_n & pc_we_c;
    assign alu_a_sel = rst_n & alu_a_sel_c;
    assign alu_b_sel = rst_n & alu_b_sel_c;
    assign rf_we     = rst_n & rf_we_c;
    assign pc_sel    = rst_n ? pc_sel_c : 2'b00;
    assign wb_sel    = rst_n ? wb_sel_c : 2'b00;

    assign state_o = state_q;
    assign trap    = trap_q;
    assign halt    = halt_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: an instruction-level model expands
// each instruction into its expected per-cycle control trace.
module tb_multicycle_ctrl;

    localparam int unsigned MEM_TIMEOUT = 16;
    localparam int unsigned CNT_W       = 32;

    localparam logic [6:0] O_OP     = 7'b0110011;
    localparam logic [6:0] O_OPIMM  = 7'b0010011;
    localparam logic [6:0] O_LOAD   = 7'b0000011;
    localparam logic [6:0] O_STORE  = 7'b0100011;
    localparam logic [6:0] O_BRANCH = 7'b1100011;
    localparam logic [6:0] O_JAL    = 7'b1101111;
    localparam logic [6:0] O_JALR   = 7'b1100111;
    localparam logic [6:0] O_LUI    = 7'b0110111;
    localparam logic [6:0] O_AUIPC  = 7'b0010111;
    localparam logic [6:0] O_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [2:0] st;
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       a_sel;
        logic       b_sel;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       trap;
        logic       halt;
    } obs_t;

    logic             clk;
    logic             rst_n;
    logic [6:0]       opcode;
    logic [2:0]       func3;
    logic             branch_cond;
    logic             imem_ack;
    logic             dmem_ack;
    logic             imem_req;
    logic             dmem_req;
    logic             dmem_we;
    logic             ir_we;
    logic             pc_we;
    logic [1:0]       pc_sel;
    logic             alu_a_sel;
    logic             alu_b_sel;
    logic             rf_we;
    logic [1:0]       wb_sel;
    logic [2:0]       state_o;
    logic             trap;
    logic             halt;
    logic [CNT_W-1:0] instret;

    multicycle_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .func3(func3),
        .branch_cond(branch_cond), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .alu_a_sel(alu_a_sel),
        .alu_b_sel(alu_b_sel), .rf_we(rf_we), .wb_sel(wb_sel),
        .state_o(state_o), .trap(trap), .halt(halt), .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int unsigned model_ret = 0;
    logic        model_trap = 1'b0;
    logic        model_halt = 1'b0;

    obs_t exp_q[$];
    logic iack_q[$];
    logic dack_q[$];

    logic [6:0] legal_ops [9] = '{O_OP, O_OPIMM, O_LOAD, O_STORE, O_BRANCH,
                                  O_JAL, O_JALR, O_LUI, O_AUIPC};

    function automatic obs_t base(input logic [2:0] st);
        obs_t o;
        o      = '0;
        o.st   = st;
        o.trap = model_trap;
        o.halt = model_halt;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t s;
        s.st       = state_o;
        s.imem_req = imem_req;
        s.dmem_req = dmem_req;
        s.dmem_we  = dmem_we;
        s.ir_we    = ir_we;
        s.pc_we    = pc_we;
        s.pc_sel   = pc_sel;
        s.a_sel    = alu_a_sel;
        s.b_sel    = alu_b_sel;
        s.rf_we    = rf_we;
        s.wb_sel   = wb_sel;
        s.trap     = trap;
        s.halt     = halt;
        return s;
    endfunction

    task automatic push(input obs_t o, input logic ia, input logic da);
        exp_q.push_back(o);
        iack_q.push_back(ia);
        dack_q.push_back(da);
    endtask

    // Replay the expected trace cycle by cycle; entered at posedge+1
    task automatic play(input string tag);
        obs_t e;
        obs_t got;
        int   cyc;
        cyc = 0;
        while (exp_q.size() > 0) begin
            e        = exp_q.pop_front();
            imem_ack = iack_q.pop_front();
            dmem_ack = dack_q.pop_front();
            @(negedge clk);
            got = sample();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s cycle %0d: got %h want %h", tag, cyc, got, e);
            end
            cyc++;
            @(posedge clk);
            #1;
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
    endtask

    task automatic push_fetch(input int di);
        obs_t o;
        for (int k = 0; k <= di; k++) begin
            o          = base(3'd0);
            o.imem_req = 1'b1;
            o.ir_we    = (k == di);
            push(o, k == di, 1'b0);
        end
        push(base(3'd1), 1'b0, 1'b0);
    endtask

    task automatic push_stop(input int n);
        for (int k = 0; k < n; k++) push(base(3'd5), 1'b0, 1'b0);
    endtask

    // Expected trace for one legal, non-SYSTEM instruction
    task automatic model_instr(input logic [6:0] opc, input logic bc, input int di, input int dd);
        obs_t o;
        push_fetch(di);
        o = base(3'd2);
        if (opc == O_OP || opc == O_OPIMM || opc == O_LUI || opc == O_AUIPC) begin
            o.a_sel = (opc == O_AUIPC);
            o.b_sel = (opc == O_OPIMM || opc == O_AUIPC);
            push(o, 1'b0, 1'b0);
            o        = base(3'd4);
            o.rf_we  = 1'b1;
            o.wb_sel = (opc == O_LUI) ? 2'd3 : 2'd0;
            o.pc_we  = 1'b1;
            push(o, 1'b0, 1'b0);
        end else if (opc == O_LOAD || opc == O_STORE) begin
            o.b_sel = 1'b1;
            push(o, 1'b0, 1'b0);
            for (int k = 0; k <= dd; k++) begin
                o          = base(3'd3);
                o.dmem_req = 1'b1;
                o.dmem_we  = (opc == O_STORE);
                o.pc_we    = (opc == O_STORE) && (k == dd);
                push(o, 1'b0, k == dd);
            end
            if (opc == O_LOAD) begin
                o        = base(3'd4);
                o.rf_we  = 1'b1;
                o.wb_sel = 2'd1;
                o.pc_we  = 1'b1;
                push(o, 1'b0, 1'b0);
            end
        end else if (opc == O_BRANCH) begin
            o.pc_we  = 1'b1;
            o.pc_sel = bc ? 2'd1 : 2'd0;
            push(o, 1'b0, 1'b0);
        end else begin
            o.pc_sel = (opc == O_JAL) ? 2'd1 : 2'd2;
            o.b_sel  = (opc == O_JALR);
            o.rf_we  = 1'b1;
            o.wb_sel = 2'd2;
            o.pc_we  = 1'b1;
            push(o, 1'b0, 1'b0);
        end
        model_ret++;
    endtask

    task automatic run_instr(input logic [6:0] opc, input logic bc, input int di,
                             input int dd, input string tag);
        opcode      = opc;
        func3       = 3'($urandom_range(7, 0));
        branch_cond = bc;
        model_instr(opc, bc, di, dd);
        play(tag);
        checks++;
        if (instret !== CNT_W'(model_ret)) begin
            errors++;
            $display("FAIL %s instret: got %0d want %0d", tag, instret, model_ret);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n      = 1'b1;
        model_ret  = 0;
        model_trap = 1'b0;
        model_halt = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (sample() !== obs_t'(0)) begin
            errors++;
            $display("FAIL reset_outputs: got %h want %h", sample(), obs_t'(0));
        end
        checks++;
        if (instret !== '0) begin
            errors++;
            $display("FAIL reset_instret: got %0d want 0", instret);
        end
        do_reset();
    endtask

    task automatic test_addi();
        run_instr(O_OPIMM, 1'b0, 0, 0, "addi");
    endtask

    task automatic test_lw();
        run_instr(O_LOAD, 1'b0, 0, 3, "lw_delay3");
    endtask

    task automatic test_branch();
        run_instr(O_BRANCH, 1'b1, 1, 0, "beq_taken");
        run_instr(O_BRANCH, 1'b0, 0, 0, "beq_not_taken");
    endtask

    task automatic test_store_ack_at_timeout();
        run_instr(O_STORE, 1'b0, 0, int'(MEM_TIMEOUT) - 1, "sw_ack_last_cycle");
        run_instr(O_LOAD, 1'b0, int'(MEM_TIMEOUT) - 1, 0, "lw_fetch_ack_last_cycle");
    endtask

    task automatic test_random();
        logic [6:0] opc;
        for (int n = 0; n < 40; n++) begin
            opc = legal_ops[$urandom_range(8, 0)];
            run_instr(opc, 1'($urandom_range(1, 0)), int'($urandom_range(4, 0)),
                      int'($urandom_range(4, 0)), "random");
        end
    endtask

    task automatic test_reset_mid_mem();
        obs_t o;
        opcode = O_LOAD;
        push_fetch(1);
        o       = base(3'd2);
        o.b_sel = 1'b1;
        push(o, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            o          = base(3'd3);
            o.dmem_req = 1'b1;
            push(o, 1'b0, 1'b0);
        end
        play("mid_mem_lead_in");
        #2;
        checks++;
        if (dmem_req !== 1'b1 || state_o !== 3'd3) begin
            errors++;
            $display("FAIL mid_mem_pre: got req=%b st=%0d want req=1 st=3", dmem_req, state_o);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (dmem_req !== 1'b0 || imem_req !== 1'b0 || state_o !== 3'd0 || instret !== '0) begin
            errors++;
            $display("FAIL mid_mem_async: got req=%b ireq=%b st=%0d ret=%0d want 0 0 0 0",
                     dmem_req, imem_req, state_o, instret);
        end
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        model_ret  = 0;
        model_trap = 1'b0;
        model_halt = 1'b0;
        run_instr(O_OP, 1'b0, 0, 0, "after_mid_reset");
    endtask

    task automatic test_illegal();
        logic [6:0] bad;
        logic       ok;
        opcode = 7'b1111111;
        push_fetch(0);
        model_trap = 1'b1;
        push_stop(20);
        play("illegal_7f");
        do_reset();
        ok = 1'b0;
        bad = 7'h00;
        while (!ok) begin
            bad = 7'($urandom_range(127, 0));
            ok  = 1'b1;
            for (int i = 0; i < 9; i++) if (legal_ops[i] == bad) ok = 1'b0;
            if (bad == O_SYSTEM) ok = 1'b0;
        end
        opcode = bad;
        push_fetch(2);
        model_trap = 1'b1;
        push_stop(5);
        play("illegal_random");
        do_reset();
    endtask

    task automatic test_halt();
        run_instr(O_OP, 1'b0, 0, 0, "pre_halt");
        opcode = O_SYSTEM;
        push_fetch(1);
        model_halt = 1'b1;
        push_stop(8);
        play("halt");
        checks++;
        if (instret !== CNT_W'(1)) begin
            errors++;
            $display("FAIL halt_instret: got %0d want 1", instret);
        end
        do_reset();
    endtask

    task automatic test_fetch_timeout();
        obs_t o;
        opcode = O_OP;
        for (int k = 0; k < int'(MEM_TIMEOUT); k++) begin
            o          = base(3'd0);
            o.imem_req = 1'b1;
            push(o, 1'b0, 1'b0);
        end
        model_trap = 1'b1;
        push_stop(4);
        play("fetch_timeout");
        do_reset();
    endtask

    task automatic test_store_timeout();
        obs_t o;
        opcode = O_STORE;
        push_fetch(0);
        o       = base(3'd2);
        o.b_sel = 1'b1;
        push(o, 1'b0, 1'b0);
        for (int k = 0; k < int'(MEM_TIMEOUT); k++) begin
            o          = base(3'd3);
            o.dmem_req = 1'b1;
            o.dmem_we  = 1'b1;
            push(o, 1'b0, 1'b0);
        end
        model_trap = 1'b1;
        push_stop(4);
        play("store_timeout");
        checks++;
        if (instret !== '0) begin
            errors++;
            $display("FAIL store_timeout_instret: got %0d want 0", instret);
        end
        do_reset();
    endtask

    initial begin
        rst_n       = 1'b0;
        opcode      = 7'h00;
        func3       = 3'd0;
        branch_cond = 1'b0;
        imem_ack    = 1'b0;
        dmem_ack    = 1'b0;
        test_reset();
        test_addi();
        test_lw();
        test_branch();
        test_store_ack_at_timeout();
        test_random();
        test_reset_mid_mem();
        test_illegal();
        test_halt();
        test_fetch_timeout();
        test_store_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
